// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues pc to a synchronous instruction memory, captures
// returned words with their address in a 2-entry buffer and presents them to decode.
module fetch_unit #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] pc,
  output logic         fetch_en,
  input  logic         flush,
  input  logic         halt,
  output logic [D-1:0] imem_addr,
  input  logic [W-1:0] imem_rdata,
  output logic [W-1:0] inst,
  output logic [D-1:0] inst_pc,
  output logic         inst_valid,
  input  logic         inst_ready
);

  logic [1:0]   count_reg, count_next;
  logic         wp_reg, rp_reg;
  logic         infl_reg;
  logic [D-1:0] infl_pc_reg;
  logic [W-1:0] buf_inst_reg [2];
  logic [D-1:0] buf_pc_reg   [2];

  logic         pop;
  logic         capture;
  logic [2:0]   occupancy;

  assign imem_addr  = pc;
  assign inst_valid = (count_reg != 2'd0) && !flush;
  assign pop        = inst_valid && inst_ready;
  assign capture    = infl_reg && !flush;
  assign occupancy  = {1'b0, count_reg} + {2'b00, infl_reg};

  // An issue is allowed only if the slot freed by this cycle's pop keeps
  // buffered plus in-flight entries within the two buffer slots.
  assign fetch_en = reset && !flush && !halt &&
                    (occupancy < (3'd2 + {2'b00, pop}));

  assign inst    = buf_inst_reg[rp_reg];
  assign inst_pc = buf_pc_reg[rp_reg];

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      count_next = count_reg + {1'b0, capture} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg   <= 2'd0;
      wp_reg      <= 1'b0;
      rp_reg      <= 1'b0;
      infl_reg    <= 1'b0;
      infl_pc_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (flush) begin
        wp_reg   <= 1'b0;
        rp_reg   <= 1'b0;
        infl_reg <= 1'b0;
      end else begin
        if (capture) wp_reg <= ~wp_reg;
        if (pop)     rp_reg <= ~rp_reg;
        infl_reg <= fetch_en;
      end
      if (fetch_en) infl_pc_reg <= pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_inst_reg[i] <= '0;
        buf_pc_reg[i]   <= '0;
      end
    end else if (capture) begin
      buf_inst_reg[wp_reg] <= imem_rdata;
      buf_pc_reg[wp_reg]   <= infl_pc_reg;
    end
  end

endmodule
